// File: rtl/lcd_char_writer.sv
// lcd_char_writer: HD44780-style 8-bit write-only LCD engine with power-up init and valid/ready byte writes
//   clk/rst                 1 kHz clock, synchronous active-high reset
//   wr_req/wr_rs/wr_data    write request, register select, byte (captured when wr_ready=1)
//   wr_ready/init_done      engine idle / init sequence completed (sticky)
//   lcd_e/lcd_rs/lcd_rw/lcd_data  registered LCD pins (lcd_rw tied to write)
module lcd_char_writer #(
   parameter int INIT_WAIT_CYC = 20,
   parameter int E_HIGH_CYC    = 1,
   parameter int CLR_WAIT_CYC  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_req,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       init_done,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);
   localparam int MAXP = (INIT_WAIT_CYC > E_HIGH_CYC) ?
                         ((INIT_WAIT_CYC > CLR_WAIT_CYC) ? INIT_WAIT_CYC : CLR_WAIT_CYC) :
                         ((E_HIGH_CYC > CLR_WAIT_CYC) ? E_HIGH_CYC : CLR_WAIT_CYC);
   localparam int CW = $clog2(MAXP + 1);
   localparam logic [CW-1:0] PW_LAST  = CW'(INIT_WAIT_CYC - 1);
   localparam logic [CW-1:0] EH_LAST  = CW'(E_HIGH_CYC - 1);
   localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT_CYC - 1);

   typedef enum logic [2:0] {PWR_WAIT, SETUP, E_HI, HOLD, WAIT, IDLE} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, wait_last;
   logic [1:0]    idx, idx_n;
   logic          done_n, e_n, rs_n;
   logic [7:0]    data_n;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      return (i == 2'd0) ? 8'h38 : (i == 2'd1) ? 8'h0C : (i == 2'd2) ? 8'h06 : 8'h01;
   endfunction

   // clear/home need the long post-write wait; the byte on the bus is the one being written
   assign wait_last = (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02)) ? CLR_LAST : '0;
   assign wr_ready  = (state == IDLE);
   assign lcd_rw    = 1'b0;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      done_n  = init_done;
      rs_n    = lcd_rs;
      data_n  = lcd_data;
      case (state)
         PWR_WAIT: begin
            if (cnt == PW_LAST) begin
               state_n = SETUP;
               cnt_n   = '0;
               rs_n    = 1'b0;
               data_n  = init_cmd(idx);
            end else cnt_n = cnt + 1'b1;
         end
         SETUP: state_n = E_HI;
         E_HI: begin
            if (cnt == EH_LAST) begin
               state_n = HOLD;
               cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
         end
         HOLD: state_n = WAIT;
         WAIT: begin
            if (cnt == wait_last) begin
               cnt_n = '0;
               if (init_done) state_n = IDLE;
               else if (idx == 2'd3) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  state_n = SETUP;
                  idx_n   = idx + 2'd1;
                  rs_n    = 1'b0;
                  data_n  = init_cmd(idx + 2'd1);
               end
            end else cnt_n = cnt + 1'b1;
         end
         IDLE: begin
            if (wr_req) begin
               state_n = SETUP;
               rs_n    = wr_rs;
               data_n  = wr_data;
            end
         end
         default: state_n = PWR_WAIT;
      endcase
      e_n = (state_n == E_HI);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PWR_WAIT;
         cnt       <= '0;
         idx       <= '0;
         init_done <= 1'b0;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= 8'h00;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         init_done <= done_n;
         lcd_e     <= e_n;
         lcd_rs    <= rs_n;
         lcd_data  <= data_n;
      end
   end
endmodule

// File: tb/tb_lcd_char_writer.sv
// tb_lcd_char_writer: directed self-checking bench for lcd_char_writer with default parameters
module tb_lcd_char_writer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_req = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready, init_done, lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;
   int         n_tests = 0;
   int         n_fail = 0;

   lcd_char_writer dut (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_rs(wr_rs), .wr_data(wr_data),
      .wr_ready(wr_ready), .init_done(init_done), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw), .lcd_data(lcd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // rst was sampled high at the previous edge and is low from now on
   task automatic run_init();
      logic [7:0] b [4];
      int hi = 0, rises = 0, first_ready = 0;
      logic prev = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (lcd_e) begin
            hi++;
            if (!prev && rises < 4) b[rises] = lcd_data;
            if (!prev) rises++;
         end
         prev = lcd_e;
         if (lcd_rw !== 1'b0) chk("init_rw", lcd_rw, 0);
         if (wr_ready) begin
            first_ready = n;
            break;
         end
      end
      chk("init_ready_cycle", first_ready, 37);
      chk("init_done", init_done, 1);
      chk("init_e_high_cycles", hi, 4);
      chk("init_e_pulses", rises, 4);
      chk("init_b0", b[0], 8'h38);
      chk("init_b1", b[1], 8'h0C);
      chk("init_b2", b[2], 8'h06);
      chk("init_b3", b[3], 8'h01);
   endtask

   task automatic do_write(input logic rs, input logic [7:0] d, input int w);
      int n;
      wr_rs = rs;
      wr_data = d;
      wr_req = 1'b1;
      for (n = 0; n < 20 && !wr_ready; n++) tick();
      chk("pre_ready", wr_ready, 1);
      tick();
      wr_req = 1'b0;
      wr_rs = ~rs;
      wr_data = ~d;
      chk("setup_rs", lcd_rs, rs);
      chk("setup_data", lcd_data, d);
      chk("setup_e", lcd_e, 0);
      chk("setup_ready", wr_ready, 0);
      tick();
      chk("ehi_e", lcd_e, 1);
      chk("ehi_data", lcd_data, d);
      tick();
      chk("hold_e", lcd_e, 0);
      chk("hold_rs", lcd_rs, rs);
      tick();
      chk("wait_e", lcd_e, 0);
      n = 3;
      while (!wr_ready && n < 20) begin
         tick();
         n++;
      end
      chk("write_gap", n, 3 + w);
      chk("idle_data", lcd_data, d);
   endtask

   initial begin
      logic [7:0] seen [3];
      int pulses, rw_bad;
      logic prev;
      tick();
      tick();
      chk("rst_e", lcd_e, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_rw", lcd_rw, 0);
      chk("rst_data", lcd_data, 8'h00);
      chk("rst_ready", wr_ready, 0);
      chk("rst_done", init_done, 0);
      rst = 1'b0;
      wr_req = 1'b1;
      wr_rs = 1'b1;
      wr_data = 8'h55;
      run_init();
      do_write(1'b1, 8'h55, 1);
      do_write(1'b1, 8'h41, 1);
      do_write(1'b0, 8'h01, 2);
      do_write(1'b0, 8'h02, 2);
      do_write(1'b1, 8'h01, 1);
      do_write(1'b0, 8'h80, 1);

      pulses = 0;
      rw_bad = 0;
      prev = 1'b0;
      wr_req = 1'b1;
      for (int i = 0; i < 15; i++) begin
         wr_rs = 1'b1;
         wr_data = 8'hA0 + 8'(i);
         tick();
         if (lcd_e && !prev) begin
            if (pulses < 3) seen[pulses] = lcd_data;
            pulses++;
         end
         prev = lcd_e;
         if (lcd_rw) rw_bad++;
      end
      wr_req = 1'b0;
      chk("b2b_pulses", pulses, 3);
      chk("b2b_byte0", seen[0], 8'hA0);
      chk("b2b_byte1", seen[1], 8'hA5);
      chk("b2b_byte2", seen[2], 8'hAA);
      chk("b2b_rw", rw_bad, 0);
      for (int i = 0; i < 20 && !wr_ready; i++) tick();

      wr_rs = 1'b1;
      wr_data = 8'h5A;
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      tick();
      chk("pre_rst_e", lcd_e, 1);
      rst = 1'b1;
      tick();
      chk("midrst_e", lcd_e, 0);
      chk("midrst_data", lcd_data, 8'h00);
      chk("midrst_ready", wr_ready, 0);
      chk("midrst_done", init_done, 0);
      rst = 1'b0;
      run_init();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
